// File: rtl/rbm_dma_pkg.sv
// Shared encodings for the RBM DMA responder: stall modes, channel FSM states
// and the stall-generator LFSR taps.
package rbm_dma_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_ALT  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2,
    ST_XFER  = 2'd3
  } dma_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, as a mask over a left-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/rbm_dma_lfsr.sv
// 16-bit Fibonacci LFSR that advances every cycle; drives the stall generator.
module rbm_dma_lfsr
  import rbm_dma_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_state
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_state <= SEED;
    else      lfsr_state <= {lfsr_state[14:0], ^(lfsr_state & LFSR_TAPS)};
  end

endmodule

// File: rtl/rbm_dma_responder.sv
// DMA responder model: independent read and write burst channels over a
// shared word memory, with selectable stall injection and a backdoor preload.
//
// state    | meaning
// ST_IDLE  | waiting for a request pulse; index/length latched on request
// ST_WAIT  | GRANT_LAT-cycle request-to-grant delay
// ST_GRANT | one-cycle grant pulse; zero length returns straight to idle
// ST_XFER  | moving beats until the length-th beat completes
module rbm_dma_responder
  import rbm_dma_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 10,
  parameter int          LEN_W     = 32,
  parameter int          GRANT_LAT = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              rd_request,
  input  logic [LEN_W-1:0]  rd_index,
  input  logic [LEN_W-1:0]  rd_length,
  output logic              rd_grant,
  output logic              data_in_valid,
  output logic [DATA_W-1:0] data_in_data,
  input  logic              data_in_ready,
  input  logic              wr_request,
  input  logic [LEN_W-1:0]  wr_index,
  input  logic [LEN_W-1:0]  wr_length,
  output logic              wr_grant,
  input  logic              data_out_valid,
  input  logic [DATA_W-1:0] data_out_data,
  output logic              data_out_ready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              rd_done,
  output logic              wr_done,
  output logic              busy
);

  localparam logic [3:0]       WAIT_LOAD = 4'(GRANT_LAT - 1);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  dma_state_e        rd_state, rd_next, wr_state, wr_next;
  logic [3:0]        rd_wait, wr_wait;
  logic [LEN_W-1:0]  rd_rem, wr_rem;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              rd_hold, rd_beat, wr_beat, rd_fin, wr_fin;
  logic              rd_stall, wr_stall, toggle;
  logic [15:0]       lfsr;
  logic              unused_bits;

  assign unused_bits = ^{rd_index[LEN_W-1:ADDR_W], wr_index[LEN_W-1:ADDR_W], lfsr[15:2]};

  rbm_dma_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .lfsr_state (lfsr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) toggle <= 1'b0;
    else      toggle <= ~toggle;
  end

  always_comb begin
    rd_stall = 1'b0;
    wr_stall = 1'b0;
    case (mode_e'(mode))
      MODE_LFSR: begin
        rd_stall = ~lfsr[0];
        wr_stall = ~lfsr[1];
      end
      MODE_ALT: begin
        rd_stall = toggle;
        wr_stall = toggle;
      end
      default: ;
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= ST_IDLE;
      wr_state <= ST_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  // next-state logic
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      ST_IDLE:  if (rd_request) rd_next = ST_WAIT;
      ST_WAIT:  if (rd_wait == 4'd0) rd_next = ST_GRANT;
      ST_GRANT: rd_next = (rd_rem == '0) ? ST_IDLE : ST_XFER;
      ST_XFER:  if (rd_beat && rd_rem == LEN_ONE) rd_next = ST_IDLE;
      default:  rd_next = ST_IDLE;
    endcase
    wr_next = wr_state;
    case (wr_state)
      ST_IDLE:  if (wr_request) wr_next = ST_WAIT;
      ST_WAIT:  if (wr_wait == 4'd0) wr_next = ST_GRANT;
      ST_GRANT: wr_next = (wr_rem == '0) ? ST_IDLE : ST_XFER;
      ST_XFER:  if (wr_beat && wr_rem == LEN_ONE) wr_next = ST_IDLE;
      default:  wr_next = ST_IDLE;
    endcase
  end

  // outputs; a pending read beat masks the stall so valid/data hold steady
  always_comb begin
    rd_grant       = (rd_state == ST_GRANT);
    wr_grant       = (wr_state == ST_GRANT);
    data_in_valid  = (rd_state == ST_XFER) && (rd_hold || !rd_stall);
    data_out_ready = (wr_state == ST_XFER) && !wr_stall;
    rd_beat        = data_in_valid && data_in_ready;
    wr_beat        = data_out_valid && data_out_ready;
    rd_fin         = (rd_state == ST_GRANT && rd_rem == '0) ||
                     (rd_state == ST_XFER && rd_beat && rd_rem == LEN_ONE);
    wr_fin         = (wr_state == ST_GRANT && wr_rem == '0) ||
                     (wr_state == ST_XFER && wr_beat && wr_rem == LEN_ONE);
    busy           = (rd_state != ST_IDLE) || (wr_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_wait <= '0;
      rd_rem  <= '0;
      rd_addr <= '0;
      rd_hold <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      rd_hold <= data_in_valid && !data_in_ready;
      rd_done <= rd_fin;
      case (rd_state)
        ST_IDLE: if (rd_request) begin
          rd_addr <= rd_index[ADDR_W-1:0];
          rd_rem  <= rd_length;
          rd_wait <= WAIT_LOAD;
        end
        ST_WAIT: if (rd_wait != 4'd0) rd_wait <= rd_wait - 4'd1;
        ST_XFER: if (rd_beat) begin
          rd_addr <= rd_addr + ADDR_ONE;
          rd_rem  <= rd_rem - LEN_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_wait <= '0;
      wr_rem  <= '0;
      wr_addr <= '0;
      wr_done <= 1'b0;
    end else begin
      wr_done <= wr_fin;
      case (wr_state)
        ST_IDLE: if (wr_request) begin
          wr_addr <= wr_index[ADDR_W-1:0];
          wr_rem  <= wr_length;
          wr_wait <= WAIT_LOAD;
        end
        ST_WAIT: if (wr_wait != 4'd0) wr_wait <= wr_wait - 4'd1;
        ST_XFER: if (wr_beat) begin
          wr_addr <= wr_addr + ADDR_ONE;
          wr_rem  <= wr_rem - LEN_ONE;
        end
        default: ;
      endcase
    end
  end

  // preload is ordered last so it wins a same-address collision with a beat
  always_ff @(posedge clk) begin
    if (wr_beat) mem[wr_addr] <= data_out_data;
    if (ld_en)   mem[ld_addr] <= ld_data;
  end

  assign data_in_data = mem[rd_addr];

endmodule

// File: tb/tb_rbm_dma_responder.sv
// Scoreboard bench for rbm_dma_responder: directed bursts push expected read
// beats; a negedge monitor pops and compares every accepted beat.
module tb_rbm_dma_responder;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              rd_request = 1'b0;
  logic [LEN_W-1:0]  rd_index = '0;
  logic [LEN_W-1:0]  rd_length = '0;
  logic              rd_grant;
  logic              data_in_valid;
  logic [DATA_W-1:0] data_in_data;
  logic              data_in_ready = 1'b1;
  logic              wr_request = 1'b0;
  logic [LEN_W-1:0]  wr_index = '0;
  logic [LEN_W-1:0]  wr_length = '0;
  logic              wr_grant;
  logic              data_out_valid = 1'b0;
  logic [DATA_W-1:0] data_out_data = '0;
  logic              data_out_ready;
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              rd_done;
  logic              wr_done;
  logic              busy;

  rbm_dma_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .GRANT_LAT(2), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .rd_request(rd_request), .rd_index(rd_index), .rd_length(rd_length),
    .rd_grant(rd_grant), .data_in_valid(data_in_valid),
    .data_in_data(data_in_data), .data_in_ready(data_in_ready),
    .wr_request(wr_request), .wr_index(wr_index), .wr_length(wr_length),
    .wr_grant(wr_grant), .data_out_valid(data_out_valid),
    .data_out_data(data_out_data), .data_out_ready(data_out_ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_done(rd_done), .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rd_xfers = 0;
  logic [DATA_W-1:0] exp_rd[$];
  logic [DATA_W-1:0] wdata[8];
  logic              prev_pend = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [DATA_W-1:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (prev_pend) begin
        check("rd_hold_valid", data_in_valid, 1);
        check("rd_hold_data", data_in_data, prev_data);
      end
      if (data_in_valid && data_in_ready) begin
        rd_xfers++;
        if (exp_rd.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_unexpected_beat: got %0h expected no beat at %0t", data_in_data, $time);
        end else begin
          mon_exp = exp_rd.pop_front();
          check("rd_beat", data_in_data, mon_exp);
        end
      end
      prev_pend = data_in_valid && !data_in_ready;
      prev_data = data_in_data;
    end else begin
      prev_pend = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int addr, input logic [DATA_W-1:0] d);
    ld_en = 1'b1; ld_addr = ADDR_W'(addr); ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // g_cyc: cycles from request to grant; d_cyc: cycles from grant to done
  task automatic rd_burst(input int idx, input int len, input bit rnd,
                          output int g_cyc, output int d_cyc);
    rd_index = LEN_W'(idx); rd_length = LEN_W'(len); rd_request = 1'b1;
    tick();
    rd_request = 1'b0;
    g_cyc = 1;
    while (!rd_grant && g_cyc < 20) begin tick(); g_cyc++; end
    check("rd_grant_seen", rd_grant, 1);
    d_cyc = 0;
    while (!rd_done && d_cyc < 400) begin
      if (rnd) data_in_ready = 1'($urandom_range(0, 1));
      tick();
      d_cyc++;
      if (d_cyc == 1) check("rd_grant_pulse", rd_grant, 0);
    end
    data_in_ready = 1'b1;
    check("rd_done", rd_done, 1);
    tick();
    check("rd_done_pulse", rd_done, 0);
    check("rd_queue_drained", exp_rd.size(), 0);
  endtask

  task automatic wr_burst(input int idx, input int len, input int nbeats, output int g_cyc);
    int n;
    wr_index = LEN_W'(idx); wr_length = LEN_W'(len); wr_request = 1'b1;
    tick();
    wr_request = 1'b0;
    g_cyc = 1;
    while (!wr_grant && g_cyc < 20) begin tick(); g_cyc++; end
    check("wr_grant_seen", wr_grant, 1);
    tick();
    for (int k = 0; k < nbeats; k++) begin
      data_out_valid = 1'b1;
      data_out_data  = wdata[k];
      n = 0;
      while (!data_out_ready && n < 50) begin tick(); n++; end
      if (n >= 50) check("wr_ready_timeout", 0, 1);
      tick();
    end
    data_out_valid = 1'b0;
  endtask

  initial begin
    int g, d, n;

    #1;
    check("rst_busy", busy, 0);
    check("rst_rd_grant", rd_grant, 0);
    check("rst_wr_grant", wr_grant, 0);
    check("rst_in_valid", data_in_valid, 0);
    check("rst_out_ready", data_out_ready, 0);
    check("rst_rd_done", rd_done, 0);
    check("rst_wr_done", wr_done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // basic read, mode 0
    preload(4, 32'hAAAA_0001);
    preload(5, 32'hBBBB_0002);
    preload(6, 32'hCCCC_0003);
    exp_rd.push_back(32'hAAAA_0001);
    exp_rd.push_back(32'hBBBB_0002);
    exp_rd.push_back(32'hCCCC_0003);
    rd_burst(4, 3, 1'b0, g, d);
    check("rd_grant_latency", g, 3);
    check("rd_back_to_back", d, 4);

    // write with address wrap, then read it back across the wrap
    wdata[0] = 32'h1234_5678;
    wdata[1] = 32'h9ABC_DEF0;
    wr_burst(1023, 2, 2, g);
    check("wr_grant_latency", g, 3);
    check("wr_done", wr_done, 1);
    tick();
    check("wr_done_pulse", wr_done, 0);
    exp_rd.push_back(32'h1234_5678);
    exp_rd.push_back(32'h9ABC_DEF0);
    rd_burst(1023, 2, 1'b0, g, d);
    check("rd_wrap_cycles", d, 3);

    // zero-length read
    rd_burst(8, 0, 1'b0, g, d);
    check("rd_len0_grant", g, 3);
    check("rd_len0_done", d, 1);

    // LFSR stalls with random consumer backpressure
    for (int i = 0; i < 8; i++) preload(100 + i, 32'hC0DE_0000 + 32'(i));
    mode = 2'd1;
    for (int i = 0; i < 8; i++) exp_rd.push_back(32'hC0DE_0000 + 32'(i));
    rd_xfers = 0;
    rd_burst(100, 8, 1'b1, g, d);
    check("rd_lfsr_xfers", rd_xfers, 8);

    // alternate-cycle stalls
    mode = 2'd2;
    for (int i = 0; i < 8; i++) exp_rd.push_back(32'hC0DE_0000 + 32'(i));
    rd_xfers = 0;
    rd_burst(100, 8, 1'b0, g, d);
    check("rd_alt_xfers", rd_xfers, 8);

    // reserved mode behaves as no stalls
    mode = 2'd3;
    for (int i = 0; i < 3; i++) exp_rd.push_back(32'hC0DE_0000 + 32'(i));
    rd_burst(100, 3, 1'b0, g, d);
    check("rd_mode3_cycles", d, 4);
    mode = 2'd0;

    // same-cycle read and write of one address
    preload(200, 32'h0000_0111);
    rd_index = 200; rd_length = 1; rd_request = 1'b1;
    wr_index = 200; wr_length = 1; wr_request = 1'b1;
    exp_rd.push_back(32'h0000_0111);
    tick();
    rd_request = 1'b0; wr_request = 1'b0;
    data_out_valid = 1'b1; data_out_data = 32'h0000_0222;
    n = 0;
    while (!rd_done && n < 20) begin tick(); n++; end
    check("coll_rd_done", rd_done, 1);
    check("coll_wr_done", wr_done, 1);
    data_out_valid = 1'b0;
    tick();
    exp_rd.push_back(32'h0000_0222);
    rd_burst(200, 1, 1'b0, g, d);

    // preload wins over a same-address write beat
    wr_index = 300; wr_length = 1; wr_request = 1'b1;
    tick();
    wr_request = 1'b0;
    n = 0;
    while (!data_out_ready && n < 20) begin tick(); n++; end
    check("ldw_ready", data_out_ready, 1);
    data_out_valid = 1'b1; data_out_data = 32'h5555_5555;
    ld_en = 1'b1; ld_addr = 10'd300; ld_data = 32'h7777_7777;
    tick();
    data_out_valid = 1'b0; ld_en = 1'b0;
    check("ldw_wr_done", wr_done, 1);
    exp_rd.push_back(32'h7777_7777);
    rd_burst(300, 1, 1'b0, g, d);

    // reset mid-write after two beats
    preload(52, 32'hEEEE_0052);
    preload(53, 32'hEEEE_0053);
    wdata[0] = 32'hD000_0000; wdata[1] = 32'hD000_0001;
    wdata[2] = 32'hD000_0002; wdata[3] = 32'hD000_0003;
    wr_burst(50, 4, 2, g);
    check("midrst_pre_ready", data_out_ready, 1);
    check("midrst_pre_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_ready", data_out_ready, 0);
    check("midrst_wr_grant", wr_grant, 0);
    check("midrst_wr_done", wr_done, 0);
    check("midrst_in_valid", data_in_valid, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst_no_wr_done", wr_done, 0);
    end
    exp_rd.push_back(32'hD000_0000);
    exp_rd.push_back(32'hD000_0001);
    exp_rd.push_back(32'hEEEE_0052);
    exp_rd.push_back(32'hEEEE_0053);
    rd_burst(50, 4, 1'b0, g, d);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
